imem_dmem_port_arbiter: RTL and testbench
=========================================

// Module: imem_dmem_port_arbiter
// PURPOSE
//   Shares one single-port synchronous SRAM between the instruction-fetch requester
//   (pre-IF next-PC fetch) and the data requester (MEM-stage load/store).
//   Grants at most one access per cycle and routes the 1-cycle-latency read data
//   back to the owner. Data has priority; an anti-starvation counter forces an
//   instruction grant after STARVE_MAX consecutive data wins.
// PARAMETERS
//   ADDR_W      32  address width
//   DATA_W      32  data width; byte-enable width is DATA_W/8
//   STARVE_MAX  4   max consecutive data grants while inst_req is pending (legal range >=1)
// PORTS
//   clk          in   1         clock, rising edge
//   reset        in   1         asynchronous, active-high
//   inst_req     in   1         fetch request, this cycle
//   inst_addr    in   ADDR_W    fetch address
//   inst_gnt     out  1         fetch accepted this cycle (combinational)
//   inst_rvalid  out  1         inst_rdata is valid (cycle after inst_gnt)
//   inst_rdata   out  DATA_W    fetched word
//   data_req     in   1         load/store request
//   data_we      in   DATA_W/8  byte write enables; 0 means load
//   data_addr    in   ADDR_W    load/store address
//   data_wdata   in   DATA_W    store data
//   data_gnt     out  1         data access accepted this cycle (combinational)
//   data_rvalid  out  1         data_rdata is valid (cycle after a load grant)
//   data_rdata   out  DATA_W    loaded word
//   sram_en      out  1         SRAM enable
//   sram_we      out  DATA_W/8  SRAM byte write enables
//   sram_addr    out  ADDR_W    SRAM address
//   sram_wdata   out  DATA_W    SRAM write data
//   sram_rdata   in   DATA_W    SRAM read data, valid the cycle after sram_en with sram_we==0
// BEHAVIOUR
//   - Reset (async): owner<=NONE, starve_cnt<=0. While reset is high, inst_gnt, data_gnt,
//     sram_en, inst_rvalid and data_rvalid are 0; sram_we/addr/wdata are 0.
//   - Grant: force = inst_req && starve_cnt==STARVE_MAX.
//     data_gnt = data_req && !force.
//     inst_gnt = inst_req && (!data_req || force).
//     The two grants are never both 1.
//   - SRAM mux: sram_en = inst_gnt|data_gnt.
//     On data_gnt: addr/we/wdata come from the data_* ports.
//     On inst_gnt: addr=inst_addr, we=0, wdata=0.
//     With no grant: addr, we and wdata are all 0.
//   - owner register (states NONE / INST / DRD), updated every clock:
//     INST if inst_gnt; DRD if data_gnt && data_we==0; NONE otherwise (covers stores and idle).
//   - Read return: inst_rvalid=(owner==INST); data_rvalid=(owner==DRD).
//     Both rdata ports are driven by sram_rdata, gated to 0 when the matching rvalid is 0.
//     Latency: exactly 1 cycle from grant to rvalid.
//     Stores produce no rvalid; data_gnt is their completion.
//   - Pipelining: a new grant is allowed in the same cycle an earlier read returns.
//     Full throughput is 1 access per cycle with no bubbles.
//   - starve_cnt, width $clog2(STARVE_MAX+1):
//     cleared when inst_gnt or !inst_req;
//     +1 when inst_req && data_gnt, saturating at STARVE_MAX.
//   - Requesters hold req/addr/we/wdata stable until they are granted. The arbiter stores no request.
//   - Reset mid-access: the in-flight read is dropped, with no rvalid after reset deasserts.
//     The requester must re-issue.
//   - Both requests idle: sram_en=0, and owner goes to NONE on the next clock.
// TESTING
//   1. Reset, then inst_req=1 addr=0x1c000000 and data_req=0
//      -> inst_gnt=1 and sram_addr=0x1c000000 in the same cycle;
//      next cycle inst_rvalid=1 and inst_rdata=sram_rdata.
//   2. inst_req and data_req (load 0x1c000100) in the same cycle
//      -> data_gnt=1, inst_gnt=0, sram_we=0;
//      next cycle data_rvalid=1 and inst_rvalid=0.
//   3. Store data_we=4'b0011 addr=0x1c000200 wdata=0xdeadbeef
//      -> sram_we=4'b0011 and sram_wdata=0xdeadbeef; no data_rvalid on the next cycle.
//   4. STARVE_MAX=4, data_req=1 and inst_req=1 held for 10 cycles
//      -> grant pattern D,D,D,D,I,D,D,D,D,I.
//   5. Back-to-back: inst grant in cycle 0 and data load grant in cycle 1
//      -> inst_rvalid in cycle 1 and data_rvalid in cycle 2, with no bubble.
//   6. Assert reset the cycle after an inst grant
//      -> inst_rvalid stays 0 and all grants are 0 while reset is high;
//      after reset deasserts, starve_cnt=0 and owner=NONE.

Source files
------------

// File: rtl/imem_dmem_port_arbiter.sv
// Arbiter sharing one single-port SRAM between instruction fetch and data access.
// Data has priority; an anti-starvation counter eventually forces a fetch grant.
module imem_dmem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_gnt,
    output logic                inst_rvalid,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_gnt,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DRD  = 2'd2
    } owner_e;

    owner_e           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             force_inst;

    // Grants are held low during reset so nothing reaches the SRAM.
    always_comb begin
        force_inst = inst_req && (starve_cnt == CNT_MAX);
        data_gnt   = !reset && data_req && !force_inst;
        inst_gnt   = !reset && inst_req && (!data_req || force_inst);
    end

    always_comb begin
        sram_en    = inst_gnt | data_gnt;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        unique case (1'b1)
            data_gnt: begin
                sram_we    = data_we;
                sram_addr  = data_addr;
                sram_wdata = data_wdata;
            end
            inst_gnt: begin
                sram_addr  = inst_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        inst_rvalid = (owner == OWN_INST);
        data_rvalid = (owner == OWN_DRD);
        inst_rdata  = inst_rvalid ? sram_rdata : '0;
        data_rdata  = data_rvalid ? sram_rdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            if (inst_gnt)
                owner <= OWN_INST;
            else if (data_gnt && (data_we == BE_W'(0)))
                owner <= OWN_DRD;
            else
                owner <= OWN_NONE;

            if (inst_gnt || !inst_req)
                starve_cnt <= '0;
            else if (data_gnt && (starve_cnt != CNT_MAX))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Bench for imem_dmem_port_arbiter: directed vectors plus a cycle model
// that tracks the starvation streak and the previous cycle's read winner.
module tb_imem_dmem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic [3:0]  data_we = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    int errors = 0;
    int checks = 0;

    imem_dmem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: data wins unless fetch has lost STARVE_MAX times in a row.
    int streak = 0;
    int prev_win = 0;

    function automatic void model_gnt(output logic ig, output logic dg);
        if (reset) begin
            ig = 1'b0;
            dg = 1'b0;
        end else begin
            dg = data_req && !(inst_req && streak >= STARVE_MAX);
            ig = inst_req && !dg;
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        logic ig, dg;
        if (reset) begin
            streak   = 0;
            prev_win = 0;
        end else begin
            model_gnt(ig, dg);
            prev_win = ig ? 1 : ((dg && data_we == 4'h0) ? 2 : 0);
            if (inst_req && dg)
                streak = (streak < STARVE_MAX) ? streak + 1 : STARVE_MAX;
            else
                streak = 0;
        end
    end

    always @(negedge clk) begin
        logic ig, dg;
        logic [31:0] ea, ew;
        logic [3:0]  ebe;
        model_gnt(ig, dg);
        ea  = dg ? data_addr : (ig ? inst_addr : 32'h0);
        ebe = dg ? data_we : 4'h0;
        ew  = dg ? data_wdata : 32'h0;
        chk("m_gnt", {inst_gnt, data_gnt, sram_en}, {ig, dg, ig | dg});
        chk("m_sram", {sram_we, sram_addr, sram_wdata}, {ebe, ea, ew});
        chk("m_rvalid", {inst_rvalid, data_rvalid},
            {prev_win == 1, prev_win == 2});
        chk("m_rdata", {inst_rdata, data_rdata},
            {(prev_win == 1) ? sram_rdata : 32'h0,
             (prev_win == 2) ? sram_rdata : 32'h0});
    end

    task automatic cyc(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [3:0] dwe,
                       input logic [31:0] da, input logic [31:0] dwd,
                       input logic [31:0] rd);
        @(posedge clk);
        #1;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_we    = dwe;
        data_addr  = da;
        data_wdata = dwd;
        sram_rdata = rd;
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] rd);
        cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, rd);
    endtask

    task automatic pattern(input string pat, input string tag);
        string got;
        got = pat;
        for (int i = 0; i < pat.len(); i++) begin
            cyc(1'b1, 32'h1c000400, 1'b1, 4'h0, 32'h1c000500, 32'h0,
                32'h0);
            got[i] = inst_gnt ? "I" : (data_gnt ? "D" : "-");
        end
        checks++;
        if (got != pat) begin
            errors++;
            $display("FAIL %s actual=%s required=%s", tag, got, pat);
        end
    endtask

    initial begin
        logic gi, gd;
        // Reset state, including a request presented during reset
        cyc(1'b1, 32'h1c000000, 1'b1, 4'h0, 32'h1c000100, 32'h0, 32'h0);
        chk("rst_outs", {inst_gnt, data_gnt, sram_en, inst_rvalid,
                         data_rvalid}, 5'b0);
        chk("rst_sram", {sram_we, sram_addr, sram_wdata}, 68'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);

        // 1: lone fetch
        cyc(1'b1, 32'h1c000000, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        chk("t1_gnt", {inst_gnt, data_gnt}, 2'b10);
        chk("t1_addr", sram_addr, 32'h1c000000);
        idle(32'h11112222);
        chk("t1_rvalid", inst_rvalid, 1'b1);
        chk("t1_rdata", inst_rdata, 32'h11112222);

        // 2: simultaneous fetch and load; fetch keeps requesting
        cyc(1'b1, 32'h1c000040, 1'b1, 4'h0, 32'h1c000100, 32'h0, 32'h0);
        chk("t2_gnt", {inst_gnt, data_gnt, sram_we}, {2'b01, 4'h0});
        cyc(1'b1, 32'h1c000040, 1'b0, 4'h0, 32'h0, 32'h0, 32'h33334444);
        chk("t2_rvalid", {inst_rvalid, data_rvalid}, 2'b01);
        chk("t2_rdata", data_rdata, 32'h33334444);
        chk("t2_late_inst", inst_gnt, 1'b1);

        // 3: partial store
        cyc(1'b0, 32'h0, 1'b1, 4'b0011, 32'h1c000200, 32'hdeadbeef,
            32'h55556666);
        chk("t3_we", sram_we, 4'b0011);
        chk("t3_wdata", sram_wdata, 32'hdeadbeef);
        chk("t3_gnt", data_gnt, 1'b1);
        idle(32'h77778888);
        chk("t3_no_rvalid", {data_rvalid, sram_en}, 2'b00);

        // 4: sustained contention
        pattern("DDDDIDDDDI", "t4_pattern");

        // 5: back-to-back fetch then load, no bubble
        idle(32'h0);
        cyc(1'b1, 32'h1c000010, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        chk("t5_c0", inst_gnt, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h1c000110, 32'h0, 32'ha0a0a0a0);
        chk("t5_c1", {inst_rvalid, data_gnt}, 2'b11);
        chk("t5_c1_data", inst_rdata, 32'ha0a0a0a0);
        idle(32'hb1b1b1b1);
        chk("t5_c2", {inst_rvalid, data_rvalid}, 2'b01);
        chk("t5_c2_data", data_rdata, 32'hb1b1b1b1);

        // 6: reset right after a fetch grant
        cyc(1'b1, 32'h1c000020, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        chk("t6_pre", inst_gnt, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        data_req = 1'b1;
        @(negedge clk);
        chk("t6_in_rst", {inst_rvalid, inst_gnt, data_gnt, sram_en}, 4'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        chk("t6_after", {inst_rvalid, data_rvalid}, 2'b00);
        pattern("DDDDI", "t6_cnt_cleared");

        // Random traffic, requests held until granted
        idle(32'h0);
        gi = 1'b1;
        gd = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (!inst_req || gi) begin
                inst_req  = ($urandom_range(0, 2) != 0);
                inst_addr = $urandom;
            end
            if (!data_req || gd) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_we    = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            sram_rdata = $urandom;
            @(negedge clk);
            gi = inst_gnt;
            gd = data_gnt;
        end

        idle(32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
